// File: rtl/ps2_button_mapper.sv
// PS/2 key event to button-vector mapper with a run-time rewritable key map,
// E0-extended key support and per-button tap stretching.
module ps2_button_mapper #(
    parameter int                 N_BTN       = 12,
    parameter int                 AW          = 4,
    parameter int                 HOLD_W      = 20,
    parameter int                 HOLD_CYCLES = 429545,
    parameter logic [N_BTN*9-1:0] DEFAULT_MAP = {9'h011, 9'h016, 9'h021, 9'h023,
                                                 9'h066, 9'h014, 9'h022, 9'h01B,
                                                 9'h02B, 9'h02A, 9'h01A, 9'h01C}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      ps2_key,
    input  logic             map_wr,
    input  logic [AW-1:0]    map_addr,
    input  logic [8:0]       map_data,
    input  logic             clear,
    output logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] raw,
    output logic             key_hit
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

    // Parameter sanity, caught at elaboration.
    if (N_BTN < 1 || N_BTN > 32) begin : g_bad_n_btn
        $error("ps2_button_mapper: N_BTN must be in 1..32");
    end
    if (AW < 1 || AW > 31 || (1 << AW) < N_BTN) begin : g_bad_aw
        $error("ps2_button_mapper: AW too small for N_BTN");
    end
    if (HOLD_W < 1 || HOLD_CYCLES < 0 ||
        (HOLD_W < 31 && HOLD_CYCLES >= (1 << HOLD_W))) begin : g_bad_hold
        $error("ps2_button_mapper: HOLD_CYCLES does not fit in HOLD_W bits");
    end

    logic              old_tog;
    logic              evt;
    logic              s0_valid;
    logic              s0_pressed;
    logic [8:0]        s0_key;

    logic [8:0]        map_q [N_BTN];
    logic [HOLD_W-1:0] cnt_q [N_BTN];
    logic [N_BTN-1:0]  raw_q;
    logic [N_BTN-1:0]  buttons_q;
    logic              key_hit_q;

    logic [N_BTN-1:0]  match;
    logic [N_BTN-1:0]  wr_sel;
    logic [31:0]       addr_ext;
    logic              addr_ok;

    assign evt      = ps2_key[10] ^ old_tog;
    assign addr_ext = 32'(map_addr);
    assign addr_ok  = addr_ext < 32'(N_BTN);

    // Stage 0: detect a toggle edge and latch the event fields.
    always_ff @(posedge clk) begin
        old_tog <= ps2_key[10];
        if (!reset_n) begin
            s0_valid   <= 1'b0;
            s0_pressed <= 1'b0;
            s0_key     <= 9'd0;
        end else if (clear) begin
            s0_valid   <= 1'b0;
        end else begin
            s0_valid <= evt;
            if (evt) begin
                s0_pressed <= ps2_key[9];
                s0_key     <= ps2_key[8:0];
            end
        end
    end

    // Stage 1 compare: ext is part of the key, so E0 and plain codes never alias.
    always_comb begin
        match  = '0;
        wr_sel = '0;
        for (int i = 0; i < N_BTN; i++) begin
            match[i]  = s0_valid && (map_q[i] == s0_key);
            wr_sel[i] = map_wr && addr_ok && (addr_ext == 32'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                map_q[i] <= DEFAULT_MAP[i*9 +: 9];
            end
        end else if (!clear) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (wr_sel[i]) begin
                    map_q[i] <= map_data;
                end
            end
        end
    end

    // A map write on an entry overrides any match on it in the same cycle.
    // The hold counter only reloads on a real 0->1 edge of raw, not on repeats.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            raw_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (wr_sel[i]) begin
                    raw_q[i] <= 1'b0;
                    cnt_q[i] <= '0;
                end else begin
                    if (match[i]) begin
                        raw_q[i] <= s0_pressed;
                    end
                    if (match[i] && s0_pressed && !raw_q[i]) begin
                        cnt_q[i] <= HOLD_LOAD;
                    end else if (cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - CNT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            buttons_q <= '0;
            key_hit_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                buttons_q[i] <= raw_q[i] | (cnt_q[i] != '0);
            end
            key_hit_q <= |match;
        end
    end

    assign buttons = buttons_q;
    assign raw     = raw_q;
    assign key_hit = key_hit_q;

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Directed bench for ps2_button_mapper: a table of key events on the default
// map plus hand-written sequences for stretch timing, map writes and clear.
module tb_ps2_button_mapper;

    localparam int N_BTN = 12;
    localparam int AW    = 4;

    logic             clk;
    logic             reset_n;
    logic [10:0]      ps2_key;
    logic             map_wr;
    logic [AW-1:0]    map_addr;
    logic [8:0]       map_data;
    logic             clear;
    logic [N_BTN-1:0] buttons;
    logic [N_BTN-1:0] raw;
    logic             key_hit;

    int   checks   = 0;
    int   failures = 0;
    logic tog      = 1'b1;

    ps2_button_mapper #(
        .N_BTN      (N_BTN),
        .AW         (AW),
        .HOLD_W     (20),
        .HOLD_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .map_wr  (map_wr),
        .map_addr(map_addr),
        .map_data(map_data),
        .clear   (clear),
        .buttons (buttons),
        .raw     (raw),
        .key_hit (key_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pressed;
        logic        ext;
        logic [7:0]  code;
        logic [11:0] exp_raw;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [11];

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic map_write(input logic [AW-1:0] addr, input logic [8:0] data);
        map_wr   = 1'b1;
        map_addr = addr;
        map_data = data;
        step();
        map_wr   = 1'b0;
    endtask

    initial begin
        logic seen_hit;

        // Default map bit order: 1C,1A,2A,2B,1B,22,14,66,23,21,16,11 = bits 0..11
        vecs[0]  = '{1'b1, 1'b0, 8'h1C, 12'h001, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h16, 12'h401, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'h1C, 12'h401, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h1C, 12'h400, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h66, 12'h480, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h11, 12'hC80, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h16, 12'h880, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h5A, 12'h880, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h66, 12'h800, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h11, 12'h000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h29, 12'h000, 1'b0};

        reset_n  = 1'b0;
        ps2_key  = {tog, 10'd0};
        map_wr   = 1'b0;
        map_addr = '0;
        map_data = '0;
        clear    = 1'b0;

        // Test 1: toggle held high through reset must not create an event.
        step(3);
        check("reset_raw", 32'(raw), 32'h0);
        check("reset_buttons", 32'(buttons), 32'h0);
        reset_n  = 1'b1;
        seen_hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen_hit |= key_hit;
        end
        check("idle_key_hit", 32'(seen_hit), 32'h0);
        check("idle_buttons", 32'(buttons), 32'h0);

        // Test 2: stretch timing with HOLD_CYCLES=8.
        send(1'b1, 1'b0, 8'h1C);
        step();
        check("t2_raw_T1", 32'(raw), 32'h0);
        step();
        check("t2_raw_T2", 32'(raw), 32'h001);
        check("t2_hit_T2", 32'(key_hit), 32'h1);
        check("t2_btn_T2", 32'(buttons), 32'h0);
        step();
        check("t2_btn_T3", 32'(buttons), 32'h001);
        check("t2_hit_T3", 32'(key_hit), 32'h0);
        step();
        send(1'b0, 1'b0, 8'h1C);
        step(2);
        check("t2_raw_T6", 32'(raw), 32'h0);
        check("t2_hit_T6", 32'(key_hit), 32'h1);
        for (int t = 7; t <= 10; t++) begin
            step();
            check($sformatf("t2_btn_T%0d", t), 32'(buttons), 32'h001);
        end
        step();
        check("t2_btn_T11", 32'(buttons), 32'h0);
        step(3);

        // Table of single events on the default map.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].pressed, vecs[i].ext, vecs[i].code);
            step(2);
            check($sformatf("vec%0d_raw", i), 32'(raw), 32'(vecs[i].exp_raw));
            check($sformatf("vec%0d_hit", i), 32'(key_hit), 32'(vecs[i].exp_hit));
            step();
            check($sformatf("vec%0d_hit_drop", i), 32'(key_hit), 32'h0);
        end
        step(12);
        check("drain_buttons", 32'(buttons), 32'h0);

        // Test 3: E0 and plain versions of the same scancode on separate entries.
        map_write(4'd3, 9'h175);
        map_write(4'd4, 9'h075);
        send(1'b1, 1'b1, 8'h75);
        step(2);
        check("t3_ext_only", 32'(raw), 32'h008);
        send(1'b1, 1'b0, 8'h75);
        step(2);
        check("t3_plain_too", 32'(raw), 32'h018);
        send(1'b0, 1'b1, 8'h75);
        step(2);
        send(1'b0, 1'b0, 8'h75);
        step(2);
        check("t3_released", 32'(raw), 32'h0);
        step(12);

        // Test 4: map write collides with a repeat make on the same entry.
        send(1'b1, 1'b0, 8'h1A);
        step(2);
        check("t4_hold", 32'(raw), 32'h002);
        step(2);
        send(1'b1, 1'b0, 8'h1A);
        step();
        map_write(4'd1, 9'h029);
        check("t4_write_wins_raw", 32'(raw), 32'h0);
        step();
        check("t4_write_wins_btn", 32'(buttons), 32'h0);
        send(1'b1, 1'b0, 8'h29);
        step(2);
        check("t4_new_key", 32'(raw), 32'h002);
        send(1'b0, 1'b0, 8'h29);
        step(2);
        send(1'b1, 1'b0, 8'h1A);
        step(2);
        check("t4_old_key_hit", 32'(key_hit), 32'h0);
        check("t4_old_key_raw", 32'(raw), 32'h0);
        step(12);

        // Test 5: clear drops an in-flight event and zeroes everything.
        send(1'b1, 1'b0, 8'h16);
        step();
        send(1'b1, 1'b0, 8'h11);
        step();
        check("t5_first_raw", 32'(raw), 32'h400);
        check("t5_first_hit", 32'(key_hit), 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_clear_btn", 32'(buttons), 32'h0);
        check("t5_clear_raw", 32'(raw), 32'h0);
        seen_hit = key_hit;
        for (int k = 0; k < 5; k++) begin
            step();
            seen_hit |= key_hit;
        end
        check("t5_lost_hit", 32'(seen_hit), 32'h0);
        check("t5_lost_raw", 32'(raw), 32'h0);
        check("t5_lost_btn", 32'(buttons), 32'h0);

        // Test 6: out-of-range map write and an unmapped key have no effect.
        send(1'b1, 1'b0, 8'h1C);
        step(3);
        map_write(4'd15, 9'h05A);
        send(1'b1, 1'b0, 8'h5A);
        step(2);
        check("t6_hit", 32'(key_hit), 32'h0);
        check("t6_raw", 32'(raw), 32'h001);
        step();
        check("t6_btn", 32'(buttons), 32'h001);
        send(1'b0, 1'b0, 8'h1C);
        step(2);
        check("t6_map_intact", 32'(raw), 32'h0);
        check("t6_map_hit", 32'(key_hit), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
